// File: rtl/combinador_carriles.sv
// combinador_carriles: buffers four byte lanes in per-lane FIFOs and drains
// them in strict lane order 0,1,2,3 onto one registered byte stream.
// Raises pausa when any lane FIFO is almost full and keeps a sticky overflow
// flag for writes dropped on a full FIFO.
// Optional macro COMBINADOR_OVERFLOW_CNT_EN adds the saturating 8-bit
// cnt_overflow output counting dropped bytes.
module combinador_carriles #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       active,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  input  logic [7:0] data_in0,
  input  logic [7:0] data_in1,
  input  logic [7:0] data_in2,
  input  logic [7:0] data_in3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       pausa,
  output logic       error_overflow
`ifdef COMBINADOR_OVERFLOW_CNT_EN
  ,
  output logic [7:0] cnt_overflow
`endif
);

  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'(DEPTH - 1);

  logic [3:0]  valid_vec;
  logic [31:0] din_flat;
  logic [31:0] head_flat;
  logic [3:0]  push;
  logic [3:0]  pop;
  logic [3:0]  drop;
  logic [3:0]  almost;

  logic [1:0]  sel_q, sel_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_out_q, valid_out_d;
  logic        error_q, error_d;
  logic        any_pop;

  assign valid_vec = {valid3, valid2, valid1, valid0};
  assign din_flat  = {data_in3, data_in2, data_in1, data_in0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0]       mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      // Push/pop/drop decisions all use the pre-edge count, so a full FIFO
      // drops even if it pops at the same edge, and an empty one cannot pop.
      assign push[gi]   = active & valid_vec[gi] & (cnt_q != CNT_FULL);
      assign drop[gi]   = active & valid_vec[gi] & (cnt_q == CNT_FULL);
      assign pop[gi]    = (sel_q == 2'(gi)) & (cnt_q != '0);
      assign almost[gi] = (cnt_q >= CNT_ALMOST);
      assign head_flat[gi*8 +: 8] = mem_q[rd_ptr_q];

      // Next-state for pointers and occupancy; pointers wrap naturally.
      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(push[gi]) - CNT_W'(pop[gi]);
        if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // Pointer and count registers; reset discards any buffered bytes.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          cnt_q    <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          cnt_q    <= cnt_d;
        end
      end

      // Lane storage, no reset: contents are only meaningful below cnt_q.
      always_ff @(posedge clk) begin
        if (push[gi]) mem_q[wr_ptr_q] <= din_flat[gi*8 +: 8];
      end
    end
  endgenerate

  // Drain the selected lane; stall on it while empty to keep byte order.
  always_comb begin
    any_pop     = pop[sel_q];
    sel_d       = sel_q + 2'(any_pop);
    valid_out_d = any_pop;
    data_out_d  = any_pop ? head_flat[{sel_q, 3'b000} +: 8] : data_out_q;
    error_d     = error_q | (|drop);
  end

  // Output stream, selector and sticky overflow registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q       <= '0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      error_q     <= error_d;
    end
  end

  assign data_out       = data_out_q;
  assign valid_out      = valid_out_q;
  assign error_overflow = error_q;
  assign pausa          = |almost;

`ifdef COMBINADOR_OVERFLOW_CNT_EN
  logic [7:0] cnt_ovf_q, cnt_ovf_d;
  logic [2:0] drops_now;
  logic [8:0] cnt_sum;

  // Add this cycle's dropped bytes, saturating at 8'hFF.
  always_comb begin
    drops_now = 3'(drop[0]) + 3'(drop[1]) + 3'(drop[2]) + 3'(drop[3]);
    cnt_sum   = {1'b0, cnt_ovf_q} + 9'(drops_now);
    cnt_ovf_d = cnt_sum[8] ? 8'hFF : cnt_sum[7:0];
  end

  // Dropped-byte counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_ovf_q <= 8'h00;
    else        cnt_ovf_q <= cnt_ovf_d;
  end

  assign cnt_overflow = cnt_ovf_q;
`endif

endmodule

// File: tb/tb_combinador_carriles.sv
// Directed bench for combinador_carriles with a small lane-FIFO reference
// model used for the streaming scenarios.
module tb_combinador_carriles;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       active = 1'b1;
  logic       valid0 = 1'b1, valid1 = 1'b1, valid2 = 1'b1, valid3 = 1'b1;
  logic [7:0] data_in0 = 8'h11, data_in1 = 8'h22, data_in2 = 8'h33, data_in3 = 8'h44;
  logic [7:0] data_out;
  logic       valid_out;
  logic       pausa;
  logic       error_overflow;
`ifdef COMBINADOR_OVERFLOW_CNT_EN
  logic [7:0] cnt_overflow;
`endif

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [7:0] mb [4][4];
  int         mh [4];
  int         mn [4];
  int         msel;
  logic [7:0] exp_data;
  logic       exp_valid;
  logic       exp_err;
  logic       exp_pausa;
  int         drops;
  logic [7:0] pat;

  combinador_carriles #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .active(active),
    .valid0(valid0), .valid1(valid1), .valid2(valid2), .valid3(valid3),
    .data_in0(data_in0), .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .data_out(data_out), .valid_out(valid_out), .pausa(pausa),
    .error_overflow(error_overflow)
`ifdef COMBINADOR_OVERFLOW_CNT_EN
    , .cnt_overflow(cnt_overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      mh[n] = 0;
      mn[n] = 0;
    end
    msel = 0; exp_data = 8'h00; exp_valid = 1'b0; exp_err = 1'b0;
    exp_pausa = 1'b0; drops = 0;
  endtask

  // Drive one cycle of inputs, advance the model using pre-edge state,
  // then wait for the edge and settle.
  task automatic step(input logic act, input logic [3:0] v, input logic [31:0] dpk);
    int pre [4];
    active = act;
    valid0 = v[0]; valid1 = v[1]; valid2 = v[2]; valid3 = v[3];
    data_in0 = dpk[7:0]; data_in1 = dpk[15:8]; data_in2 = dpk[23:16]; data_in3 = dpk[31:24];
    for (int n = 0; n < 4; n++) pre[n] = mn[n];
    exp_valid = 1'b0;
    if (pre[msel] > 0) begin
      exp_data  = mb[msel][mh[msel]];
      mh[msel]  = (mh[msel] + 1) % 4;
      mn[msel]  = mn[msel] - 1;
      exp_valid = 1'b1;
      msel      = (msel + 1) % 4;
    end
    for (int n = 0; n < 4; n++) begin
      if (act && v[n]) begin
        if (pre[n] < 4) begin
          mb[n][(mh[n] + mn[n]) % 4] = dpk[n*8 +: 8];
          mn[n] = mn[n] + 1;
        end else begin
          drops   = drops + 1;
          exp_err = 1'b1;
        end
      end
    end
    exp_pausa = 1'b0;
    for (int n = 0; n < 4; n++) if (mn[n] >= 3) exp_pausa = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data[%0d]: got %h want 00", i, data_out); end
      total++;
      if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d]: got %b want 0", i, valid_out); end
      total++;
      if (pausa !== 1'b0) begin bad++; $display("FAIL reset_pausa[%0d]: got %b want 0", i, pausa); end
      total++;
      if (error_overflow !== 1'b0) begin bad++; $display("FAIL reset_err[%0d]: got %b want 0", i, error_overflow); end
`ifdef COMBINADOR_OVERFLOW_CNT_EN
      total++;
      if (cnt_overflow !== 8'h00) begin bad++; $display("FAIL reset_cnt[%0d]: got %h want 00", i, cnt_overflow); end
`endif
    end
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; valid3 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_burst();
    logic [7:0] want [4];
    want[0] = 8'hFF; want[1] = 8'hEE; want[2] = 8'hDD; want[3] = 8'hCC;
    step(1'b1, 4'hF, {8'hCC, 8'hDD, 8'hEE, 8'hFF});
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL burst_push_edge: valid got %b want 0", valid_out); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 4'h0, 32'h0);
      total++;
      if (valid_out !== 1'b1 || data_out !== want[i])
        begin bad++; $display("FAIL burst_out[%0d]: got v=%b d=%h want v=1 d=%h", i, valid_out, data_out, want[i]); end
      else $display("burst byte %0d = %h", i, data_out);
    end
    step(1'b1, 4'h0, 32'h0);
    total++;
    if (valid_out !== 1'b0 || data_out !== 8'hCC)
      begin bad++; $display("FAIL burst_hold: got v=%b d=%h want v=0 d=cc", valid_out, data_out); end
  endtask

  task automatic test_single_wait();
    step(1'b1, 4'b0001, 32'h0000_00A5);
    step(1'b1, 4'h0, 32'h0);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'hA5)
      begin bad++; $display("FAIL wait_a5: got v=%b d=%h want v=1 d=a5", valid_out, data_out); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'h0, 32'h0);
      total++;
      if (valid_out !== 1'b0 || data_out !== 8'hA5)
        begin bad++; $display("FAIL wait_idle[%0d]: got v=%b d=%h want v=0 d=a5", i, valid_out, data_out); end
    end
    step(1'b1, 4'b0010, 32'h0000_5A00);
    total++;
    if (valid_out !== 1'b0) begin bad++; $display("FAIL wait_5a_push: valid got %b want 0", valid_out); end
    step(1'b1, 4'h0, 32'h0);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h5A)
      begin bad++; $display("FAIL wait_5a: got v=%b d=%h want v=1 d=5a", valid_out, data_out); end
    // lanes 2 and 3 bring the selector back round to lane 0
    step(1'b1, 4'b1100, 32'h8877_0000);
    step(1'b1, 4'h0, 32'h0);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h77)
      begin bad++; $display("FAIL wait_77: got v=%b d=%h want v=1 d=77", valid_out, data_out); end
    step(1'b1, 4'h0, 32'h0);
    total++;
    if (valid_out !== 1'b1 || data_out !== 8'h88)
      begin bad++; $display("FAIL wait_88: got v=%b d=%h want v=1 d=88", valid_out, data_out); end
    $display("test_single_wait done");
  endtask

  task automatic test_pausa_flow();
    int first_pausa = -1;
    logic [3:0] v;
    for (int c = 1; c <= 30; c++) begin
      v = pausa ? 4'h0 : 4'hF;
      step(1'b1, v, {pat + 8'd3, pat + 8'd2, pat + 8'd1, pat});
      if (v != 4'h0) pat = pat + 8'd4;
      total++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data))
        begin bad++; $display("FAIL flow_out[%0d]: got v=%b d=%h want v=%b d=%h", c, valid_out, data_out, exp_valid, exp_data); end
      total++;
      if (pausa !== exp_pausa) begin bad++; $display("FAIL flow_pausa[%0d]: got %b want %b", c, pausa, exp_pausa); end
      if (pausa === 1'b1 && first_pausa < 0) first_pausa = c;
    end
    total++;
    if (first_pausa < 1 || first_pausa > 3)
      begin bad++; $display("FAIL flow_pausa_latency: got %0d want 1..3", first_pausa); end
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 4'h0, 32'h0);
      total++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data))
        begin bad++; $display("FAIL flow_drain[%0d]: got v=%b d=%h want v=%b d=%h", c, valid_out, data_out, exp_valid, exp_data); end
    end
    total++;
    if (error_overflow !== 1'b0) begin bad++; $display("FAIL flow_err: got %b want 0", error_overflow); end
    $display("test_pausa_flow done, first pausa at cycle %0d", first_pausa);
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 12; c++) begin
      step(1'b1, 4'hF, {pat + 8'd3, pat + 8'd2, pat + 8'd1, pat});
      pat = pat + 8'd4;
      total++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data))
        begin bad++; $display("FAIL ovf_out[%0d]: got v=%b d=%h want v=%b d=%h", c, valid_out, data_out, exp_valid, exp_data); end
      total++;
      if (error_overflow !== exp_err) begin bad++; $display("FAIL ovf_err[%0d]: got %b want %b", c, error_overflow, exp_err); end
      total++;
      if (pausa !== exp_pausa) begin bad++; $display("FAIL ovf_pausa[%0d]: got %b want %b", c, pausa, exp_pausa); end
    end
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 4'h0, 32'h0);
      total++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data))
        begin bad++; $display("FAIL ovf_drain[%0d]: got v=%b d=%h want v=%b d=%h", c, valid_out, data_out, exp_valid, exp_data); end
    end
    total++;
    if (error_overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", error_overflow); end
`ifdef COMBINADOR_OVERFLOW_CNT_EN
    total++;
    if (cnt_overflow !== 8'(drops)) begin bad++; $display("FAIL ovf_cnt: got %0d want %0d", cnt_overflow, drops); end
`endif
    $display("test_overflow done, drops=%0d", drops);
  endtask

  task automatic test_drain_reset();
    step(1'b1, 4'hF, 32'hD3D2_D1D0);
    step(1'b1, 4'hF, 32'hD7D6_D5D4);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 4'hF, 32'hE3E2_E1E0);
      total++;
      if (valid_out !== exp_valid || (exp_valid && data_out !== exp_data))
        begin bad++; $display("FAIL drain_out[%0d]: got v=%b d=%h want v=%b d=%h", c, valid_out, data_out, exp_valid, exp_data); end
    end
    total++;
    if (valid_out !== 1'b1) begin bad++; $display("FAIL drain_prereset_valid: got %b want 1", valid_out); end
    reset = 1'b0;
    #1;
    total++;
    if (valid_out !== 1'b0 || data_out !== 8'h00)
      begin bad++; $display("FAIL async_reset: got v=%b d=%h want v=0 d=00", valid_out, data_out); end
    total++;
    if (error_overflow !== 1'b0 || pausa !== 1'b0)
      begin bad++; $display("FAIL async_reset_flags: got err=%b pausa=%b want 0 0", error_overflow, pausa); end
    model_reset();
    active = 1'b1;
    valid0 = 1'b0; valid1 = 1'b0; valid2 = 1'b0; valid3 = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 4'h0, 32'h0);
      total++;
      if (valid_out !== 1'b0 || data_out !== 8'h00)
        begin bad++; $display("FAIL post_reset[%0d]: got v=%b d=%h want v=0 d=00", c, valid_out, data_out); end
    end
    $display("test_drain_reset done");
  endtask

  initial begin
    pat = 8'h00;
    model_reset();
    test_reset();
    test_burst();
    test_single_wait();
    test_pausa_flow();
    test_overflow();
    test_drain_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/combinador_carriles.md
Name: combinador_carriles

Overview:
Downstream neighbour of the lane recirculator in phy_tx. Accepts the four active byte lanes (recirculador_activo0..3 with valid_out_recirculador0..3) and buffers each lane in its own FIFO. Drains the FIFOs in strict lane order 0,1,2,3 onto a single registered byte stream for the serializer stage.
Provides backpressure (pausa) and a sticky overflow flag.

Parameters:
DEPTH, 4, entries per lane FIFO; power of two, >= 4
PTR_W, 2, pointer width = log2(DEPTH)

Ports:
clk  input  1  single clock; all state changes on posedge
reset  input  1  asynchronous, active-low; 0 clears all state immediately
active  input  1  link active; gates FIFO writes
valid0..valid3  input  1 each  lane byte valid (from valid_out_recirculador0..3)
data_in0..data_in3  input  8 each  lane byte (from recirculador_activo0..3)
data_out  output  8  serialized byte, registered
valid_out  output  1  data_out valid this cycle, registered
pausa  output  1  backpressure to upstream; any lane FIFO almost full
error_overflow  output  1  sticky; a write was dropped on a full FIFO

Behaviour:
- Reset (reset==0, async): FIFO pointers and counts 0, selector sel=0, data_out=8'h00, valid_out=0, error_overflow=0, pausa=0. FIFO storage is don't-care. On reset mid-operation, all buffered bytes are discarded.
- Write, per lane N, each posedge:
  - Push when active && validN && countN<DEPTH.
  - If active && validN && countN==DEPTH: byte dropped, error_overflow<=1.
  - active==0: all writes ignored, no error.
- Read, single round-robin selector sel (2 bits):
  - If count[sel]>0: pop the head of FIFO sel, data_out<=head, valid_out<=1, sel<=sel+1 (wraps 3->0).
  - If count[sel]==0: valid_out<=0, data_out holds its last value, sel unchanged. Wait on the current lane; never skip it, so byte order is preserved.
  - Reads continue while active==0, so the FIFOs drain.
- Latency: a byte pushed at edge k into an empty FIFO that sel points at appears on data_out at edge k+1, with valid_out high. Reads and writes use the pre-edge state: a FIFO that is empty before the edge cannot be popped at that edge.
- Simultaneous push and pop on the same lane: count unchanged, both pointers advance. A push on a full FIFO is dropped even if that FIFO pops at the same edge.
- Pointers wrap modulo DEPTH. Counts are PTR_W+1 bits and range 0..DEPTH.
- pausa: combinational from the count registers only. It is 1 when any countN >= DEPTH-1, else 0.
- Throughput: at most 1 byte out per cycle. The upstream stage must deassert its valids while pausa==1. The block does not enforce this.
- error_overflow clears only on reset.

Optional Feature:
Macro COMBINADOR_OVERFLOW_CNT_EN.
- Defined: adds output cnt_overflow [7:0]. It resets to 0 and increments by the number of bytes dropped in a cycle (0..4). It saturates at 8'hFF.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
1. Hold reset=0 with all valids=1, active=1, data 8'h11..8'h44 -> data_out=8'h00, valid_out=0, pausa=0, error_overflow=0 throughout.
2. One cycle with active=1, all valids=1, data_in0..3=8'hFF,8'hEE,8'hDD,8'hCC -> on the next 4 edges data_out=FF,EE,DD,CC with valid_out=1. Then valid_out=0 and data_out holds CC.
3. Only valid0 with 8'hA5 -> A5 out once; sel waits on lane 1. Ten idle cycles later, valid1 with 8'h5A -> 5A out one cycle later.
4. All lanes valid every cycle with an incrementing pattern; bench drops valids whenever pausa==1 -> pausa asserts within 3 cycles, error_overflow stays 0, and the output sequence equals the input in lane order with no loss.
5. Same as 4 but the bench ignores pausa -> error_overflow=1 and stays 1. No dropped byte ever appears on data_out. With COMBINADOR_OVERFLOW_CNT_EN, cnt_overflow equals the bench's drop count.
6. Fill FIFOs, then set active=0 with valids=1 -> no new bytes accepted, buffered bytes drain in order. Asserting reset=0 mid-drain clears valid_out and data_out in the same cycle, asynchronously.
